// File: rtl/mmio_bank.sv
// Memory-mapped register bank: N_OUT read/write output words plus a debounced,
// edge-capturing input port with a maskable level interrupt.
module mmio_bank #(
    parameter int N_OUT           = 2,
    parameter int N_IN            = 14,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 select,
    input  logic [7:0]           address,
    input  logic [3:0]           byteena,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q,
    input  logic [N_IN-1:0]      io_input_bus,
    output logic [32*N_OUT-1:0]  io_output_bus,
    output logic                 irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] ADDR_STABLE  = 8'h20;
    localparam logic [7:0] ADDR_CAPTURE = 8'h21;
    localparam logic [7:0] ADDR_ENABLE  = 8'h22;

    logic [31:0]     out_regs [N_OUT];
    logic [N_IN-1:0] sync_a, sync_b;
    logic [N_IN-1:0] stable, stable_next;
    logic [N_IN-1:0] capture, enable;
    logic [N_IN-1:0] write_bits, clear_bits;
    logic [CW-1:0]   cnt      [N_IN];
    logic [CW-1:0]   cnt_next [N_IN];
    logic [31:0]     byte_mask;
    logic [31:0]     read_data;
    logic            write_en;

    assign write_en   = select & wren;
    assign write_bits = data[N_IN-1:0] & byte_mask[N_IN-1:0];
    assign clear_bits = (write_en && address == ADDR_CAPTURE) ? write_bits : '0;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{byteena[i]}};
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            io_output_bus[32*k +: 32] = out_regs[k];
        end
    end

    // The counter flips the stable bit on the edge that completes the
    // DEBOUNCE_CYCLES-th consecutive differing sample, so it never wraps.
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            stable_next[i] = stable[i];
            cnt_next[i]    = '0;
            if (sync_b[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = sync_b[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (address == 8'(k)) begin
                read_data = out_regs[k];
            end
        end
        case (address)
            ADDR_STABLE:  read_data = 32'(stable);
            ADDR_CAPTURE: read_data = 32'(capture);
            ADDR_ENABLE:  read_data = 32'(enable);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                out_regs[k] <= '0;
            end
        end else if (write_en) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (address == 8'(k)) begin
                    out_regs[k] <= (out_regs[k] & ~byte_mask) | (data & byte_mask);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_a <= io_input_bus;
            sync_b <= sync_a;
            stable <= stable_next;
            for (int unsigned i = 0; i < N_IN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // A rising edge detected on the same cycle as a clear wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capture <= '0;
            enable  <= '0;
            irq     <= 1'b0;
        end else begin
            capture <= (capture & ~clear_bits) | (stable_next & ~stable);
            if (write_en && address == ADDR_ENABLE) begin
                enable <= (enable & ~byte_mask[N_IN-1:0]) | write_bits;
            end
            irq <= |(capture & enable);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (select) begin
            q <= read_data;
        end
    end

endmodule
